data_mem_responder: RTL and testbench

- Memory-side responder for the processor's data-memory load/store port.
- Replaces the ideal zero-latency data memory with a handshaked, fixed-latency slave holding one outstanding request.
- Array is 64-bit wide, little-endian, with byte/half/word/double accesses selected by the load/store funct3 code.
- Load sign or zero extension is done here, not in the datapath.

---
 rtl/data_mem_responder.sv | 103 ++++++++++
 tb/tb_data_mem_responder.sv | 134 +++++++++++++
 2 files changed

// File: rtl/data_mem_responder.sv
// data_mem_responder: fixed-latency handshaked data memory with one outstanding request.
// Byte/half/word/double accesses on a 64-bit little-endian array; loads are extended here.
module data_mem_responder #(
  parameter int DEPTH   = 64,
  parameter int LATENCY = 2
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_write_i,
  input  logic [63:0] req_addr_i,
  input  logic [63:0] req_wdata_i,
  input  logic [2:0]  req_size_i,
  output logic        rsp_valid_o,
  input  logic        rsp_ready_i,
  output logic [63:0] rsp_rdata_o,
  output logic        rsp_error_o
);
  localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        write_q;
  logic [63:0] addr_q, wdata_q;
  logic [2:0]  size_q;
  logic [63:0] rdata_q, rdata_d;
  logic        err_q, err_d;
  logic [63:0] mem_q [DEPTH];
  logic        idle, access, a_write, err, sign;
  logic [63:0] a_addr, a_wdata, word, mask, raw, load, store;
  logic [2:0]  a_size, off;
  logic [1:0]  sz;
  logic [AW-1:0] idx;
  // with LATENCY=1 the access happens on the acceptance edge, so operands bypass the latches
  always_comb begin
    idle    = state_q == IDLE;
    a_write = idle ? req_write_i : write_q;
    a_addr  = idle ? req_addr_i : addr_q;
    a_wdata = idle ? req_wdata_i : wdata_q;
    a_size  = idle ? req_size_i : size_q;
    sz      = a_size[1:0];
    off     = a_addr[2:0];
    err     = (sz == 2'd1 && off[0]) || (sz == 2'd2 && off[1:0] != 2'd0) || (sz == 2'd3 && off != 3'd0)
           || a_addr[63:3] >= 61'(DEPTH) || a_size == 3'b111 || (a_write && a_size[2]);
    idx     = a_addr[AW+2:3];
    word    = mem_q[idx];
    mask    = (64'd1 << (7'd8 << sz)) - 64'd1;
    raw     = (word >> {off, 3'b000}) & mask;
    sign    = ~a_size[2] & |(raw & ~(mask >> 1));
    load    = sign ? raw | ~mask : raw;
    store   = (word & ~(mask << {off, 3'b000})) | ((a_wdata & mask) << {off, 3'b000});
    access  = (idle && req_valid_i && LATENCY == 1) || (state_q == WAIT && cnt_q == 4'd1);
    state_d = state_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    if (access) begin
      state_d = RESP;
      cnt_d   = 4'd0;
      rdata_d = err || a_write ? 64'd0 : load;
      err_d   = err;
    end else if (idle && req_valid_i) begin
      state_d = WAIT;
      cnt_d   = 4'(LATENCY - 1);
    end else if (state_q == WAIT) begin
      cnt_d = cnt_q - 4'd1;
    end else if (state_q == RESP && rsp_ready_i) begin
      state_d = IDLE;
      rdata_d = '0;
      err_d   = 1'b0;
    end
  end
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      write_q <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      size_q  <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      if (idle && req_valid_i) begin
        write_q <= req_write_i;
        addr_q  <= req_addr_i;
        wdata_q <= req_wdata_i;
        size_q  <= req_size_i;
      end
    end
  end
  always_ff @(posedge clk_i)
    if (!reset_i && access && a_write && !err) mem_q[idx] <= store;
  assign req_ready_o = idle;
  assign rsp_valid_o = state_q == RESP;
  assign rsp_rdata_o = rdata_q;
  assign rsp_error_o = err_q;
endmodule

// File: tb/tb_data_mem_responder.sv
// tb_data_mem_responder: byte-array reference model drives expectations for two instances
// (LATENCY=2 and LATENCY=1); a negedge compare process checks every output every cycle.
module tb_data_mem_responder;
  localparam int DEPTH = 64;
  logic clk = 1'b0, rst0 = 1'b1, rst1 = 1'b1, sel = 1'b0;
  logic req_valid = 1'b0, req_write = 1'b0, rsp_ready = 1'b0;
  logic [63:0] req_addr = '0, req_wdata = '0;
  logic [2:0] req_size = '0;
  logic rdy0, rdy1, v0, v1, e0, e1;
  logic [63:0] d0, d1;
  logic req_ready, rsp_valid, rsp_error;
  logic [63:0] rsp_rdata;
  logic busy = 1'b0, exp_v = 1'b0, exp_e = 1'b0, chk_en = 1'b0;
  logic [63:0] exp_d = '0;
  logic [7:0] mb [2][DEPTH*8];
  int n_chk = 0, n_fail = 0;
  always #5 clk = ~clk;
  data_mem_responder #(.DEPTH(DEPTH), .LATENCY(2)) u0 (
    .clk_i(clk), .reset_i(rst0), .req_valid_i(req_valid & ~sel), .req_ready_o(rdy0),
    .req_write_i(req_write), .req_addr_i(req_addr), .req_wdata_i(req_wdata), .req_size_i(req_size),
    .rsp_valid_o(v0), .rsp_ready_i(rsp_ready & ~sel), .rsp_rdata_o(d0), .rsp_error_o(e0));
  data_mem_responder #(.DEPTH(DEPTH), .LATENCY(1)) u1 (
    .clk_i(clk), .reset_i(rst1), .req_valid_i(req_valid & sel), .req_ready_o(rdy1),
    .req_write_i(req_write), .req_addr_i(req_addr), .req_wdata_i(req_wdata), .req_size_i(req_size),
    .rsp_valid_o(v1), .rsp_ready_i(rsp_ready & sel), .rsp_rdata_o(d1), .rsp_error_o(e1));
  assign req_ready = sel ? rdy1 : rdy0;
  assign rsp_valid = sel ? v1 : v0;
  assign rsp_rdata = sel ? d1 : d0;
  assign rsp_error = sel ? e1 : e0;
  task automatic chk(input string nm, input logic [64:0] act, input logic [64:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s sel=%0d t=%0t actual=%h required=%h", nm, sel, $time, act, exp);
    end
  endtask
  always @(negedge clk) if (chk_en) begin
    chk("req_ready", req_ready, !busy);
    chk("rsp_valid", rsp_valid, exp_v);
    chk("rsp_rdata", rsp_rdata, exp_v ? exp_d : 64'd0);
    chk("rsp_error", rsp_error, exp_v & exp_e);
  end
  // called at a negedge with the selected instance idle; returns at a negedge
  task automatic xact(input logic w, input logic [63:0] a, input logic [63:0] d, input logic [2:0] s,
                      input int hold, input logic pin, input logic [63:0] lit, input logic lit_e);
    int n;
    logic e;
    logic [63:0] r;
    n = 1 << s[1:0];
    e = s == 3'b111 || (w && s[2]) || (a % 64'(n)) != 64'd0 || (a >> 3) >= 64'(DEPTH);
    r = '0;
    for (int i = 0; i < n; i++)
      if (!e && w) mb[sel][int'(a) + i] = d[8*i +: 8];
      else if (!e) r[8*i +: 8] = mb[sel][int'(a) + i];
    if (!e && !w && !s[2] && n < 8 && r[8*n-1])
      for (int i = n; i < 8; i++) r[8*i +: 8] = 8'hFF;
    req_valid = 1'b1; req_write = w; req_addr = a; req_wdata = d; req_size = s;
    @(posedge clk);
    busy = 1'b1; exp_d = r; exp_e = e;
    #1 req_valid = 1'b0;
    repeat (sel ? 0 : 1) @(posedge clk);
    exp_v = 1'b1;
    @(negedge clk);
    if (pin) begin
      chk("pin_model", {exp_e, exp_d}, {lit_e, lit});
      chk("pin_dut", {rsp_error, rsp_rdata}, {lit_e, lit});
    end
    for (int i = 0; i < hold; i++) begin
      req_valid = i == 0;
      req_write = 1'b1; req_addr = 64'h10; req_wdata = '1; req_size = 3'd3;
      @(negedge clk);
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    @(posedge clk);
    exp_v = 1'b0; busy = 1'b0;
    @(negedge clk);
    rsp_ready = 1'b0;
  endtask
  initial begin
    logic w;
    logic [2:0] s;
    logic [63:0] a;
    for (int k = 0; k < 2; k++) for (int i = 0; i < DEPTH*8; i++) mb[k][i] = 8'h00;
    repeat (2) @(negedge clk);
    chk("reset_ready", req_ready, 1'b1);
    chk("reset_valid", {rsp_valid, rsp_error, rsp_rdata}, 66'd0);
    rst0 = 1'b0; rst1 = 1'b0; chk_en = 1'b1;
    xact(1, 64'h10, 64'h1122334455667788, 3'd3, 0, 1, 64'h0, 0);
    xact(0, 64'h10, 64'h0, 3'd3, 0, 1, 64'h1122334455667788, 0);
    xact(1, 64'h13, 64'hFF, 3'd0, 1, 1, 64'h0, 0);
    xact(0, 64'h13, 64'h0, 3'd0, 0, 1, 64'hFFFFFFFFFFFFFFFF, 0);
    xact(0, 64'h13, 64'h0, 3'd4, 0, 1, 64'h00000000000000FF, 0);
    xact(0, 64'h10, 64'h0, 3'd3, 0, 1, 64'h11223344FF667788, 0);
    xact(1, 64'h20, 64'h80000001, 3'd2, 0, 1, 64'h0, 0);
    xact(0, 64'h20, 64'h0, 3'd2, 0, 1, 64'hFFFFFFFF80000001, 0);
    xact(0, 64'h20, 64'h0, 3'd6, 0, 1, 64'h0000000080000001, 0);
    xact(0, 64'h22, 64'h0, 3'd1, 0, 1, 64'hFFFFFFFFFFFF8000, 0);
    xact(0, 64'h12, 64'h0, 3'd2, 0, 1, 64'h0, 1);
    xact(1, 64'(DEPTH*8), 64'hAA, 3'd3, 0, 1, 64'h0, 1);
    xact(0, 64'((DEPTH-1)*8), 64'h0, 3'd3, 0, 1, 64'h0, 0);
    xact(0, 64'h10, 64'h0, 3'd3, 5, 1, 64'h11223344FF667788, 0);
    xact(0, 64'h0, 64'h0, 3'd7, 0, 1, 64'h0, 1);
    xact(1, 64'h8, 64'h1, 3'd4, 0, 1, 64'h0, 1);
    req_valid = 1'b1; req_write = 1'b1; req_addr = 64'h30; req_wdata = 64'h5; req_size = 3'd3;
    @(posedge clk);
    busy = 1'b1;
    #1 req_valid = 1'b0;
    @(negedge clk);
    #2 rst0 = 1'b1; busy = 1'b0; exp_v = 1'b0;
    #1 chk("async_rst_ready", req_ready, 1'b1);
    chk("async_rst_out", {rsp_valid, rsp_error, rsp_rdata}, 66'd0);
    @(negedge clk);
    rst0 = 1'b0;
    xact(0, 64'h30, 64'h0, 3'd3, 0, 1, 64'h0, 0);
    sel = 1'b1;
    xact(1, 64'h30, 64'h5, 3'd3, 0, 1, 64'h0, 0);
    xact(0, 64'h30, 64'h0, 3'd3, 2, 1, 64'h5, 0);
    xact(1, 64'h36, 64'h9ABC, 3'd1, 0, 1, 64'h0, 0);
    xact(0, 64'h36, 64'h0, 3'd5, 0, 1, 64'h9ABC, 0);
    xact(0, 64'h35, 64'h0, 3'd1, 0, 1, 64'h0, 1);
    for (int t = 0; t < 250; t++) begin
      sel = 1'($urandom_range(0, 1));
      w = 1'($urandom_range(0, 1));
      s = w && $urandom_range(0, 7) != 0 ? 3'($urandom_range(0, 3)) : 3'($urandom_range(0, 7));
      a = 64'($urandom_range(0, DEPTH*8 + 15));
      if ($urandom_range(0, 3) != 0) a = a & ~64'((1 << s[1:0]) - 1);
      if ($urandom_range(0, 24) == 0) a = {$urandom, $urandom};
      xact(w, a, {$urandom, $urandom}, s, $urandom_range(0, 3), 0, 64'h0, 0);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
